// File: rtl/fp16_normalize_round_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_normalize_round_if
// Description : Valid/ready operand and result bundle for the binary16
//               normalize-and-round stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_sig;
  logic        in_guard;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_guard, in_sticky, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_inexact
  );

  // The normalize/round stage itself.
  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_guard, in_sticky, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_inexact
  );
endinterface
`default_nettype wire

// File: rtl/fp16_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : fp16_normalize_round
// Description : Iterative (one bit per cycle) normalizer followed by
//               round-to-nearest-even and binary16 packing.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_normalize_round (
  input  logic                         clk,
  input  logic                         rst_n,
  fp16_normalize_round_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;

  // Exponent is kept 7 bits wide so carry and round increments above 31
  // remain visible for the overflow test.
  logic        sign_q,   sign_next;
  logic [6:0]  exp_q,    exp_next;
  logic [11:0] sig_q,    sig_next;
  logic        guard_q,  guard_next;
  logic        sticky_q, sticky_next;
  logic        subn_q,   subn_next;

  logic [15:0] result_q, result_next;
  logic        ovf_q,    ovf_next;
  logic        unf_q,    unf_next;
  logic        inx_q,    inx_next;

  logic        rnd_inc;
  logic [11:0] rnd_sum;
  logic [9:0]  rnd_frac;
  logic [6:0]  rnd_exp;
  logic [4:0]  rnd_field;
  logic        rnd_ovf;

  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.out_result    = result_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;
  assign bus.out_inexact   = inx_q;

  // Next-state, datapath update and rounding arithmetic.
  always_comb begin
    state_next  = state;
    sign_next   = sign_q;
    exp_next    = exp_q;
    sig_next    = sig_q;
    guard_next  = guard_q;
    sticky_next = sticky_q;
    subn_next   = subn_q;
    result_next = result_q;
    ovf_next    = ovf_q;
    unf_next    = unf_q;
    inx_next    = inx_q;

    // Round-to-nearest-even on the 11-bit significand; a carry past the
    // hidden bit renormalizes by one position.
    rnd_inc = guard_q & (sticky_q | sig_q[0]);
    rnd_sum = {1'b0, sig_q[10:0]} + {11'd0, rnd_inc};
    if (rnd_sum[11]) begin
      rnd_frac = rnd_sum[10:1];
      rnd_exp  = exp_q + 7'd1;
    end else begin
      rnd_frac = rnd_sum[9:0];
      rnd_exp  = exp_q;
    end
    // A subnormal only gains an exponent field of 1 when rounding reaches
    // the hidden bit.
    if (subn_q) begin
      rnd_field = {4'd0, rnd_sum[10]};
    end else begin
      rnd_field = rnd_exp[4:0];
    end
    rnd_ovf = !subn_q && (rnd_exp >= 7'd31);

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sign_next   = bus.in_sign;
          exp_next    = (bus.in_exp == 5'd0) ? 7'd1 : {2'b00, bus.in_exp};
          sig_next    = bus.in_sig;
          guard_next  = bus.in_guard;
          sticky_next = bus.in_sticky;
          subn_next   = 1'b0;
          state_next  = NORM;
        end
      end
      NORM: begin
        if ((sig_q == 12'd0) && !guard_q && !sticky_q) begin
          result_next = {sign_q, 15'd0};
          ovf_next    = 1'b0;
          unf_next    = 1'b0;
          inx_next    = 1'b0;
          state_next  = DONE;
        end else if (sig_q[11]) begin
          sig_next    = {1'b0, sig_q[11:1]};
          guard_next  = sig_q[0];
          sticky_next = sticky_q | guard_q;
          exp_next    = exp_q + 7'd1;
          state_next  = ROUND;
        end else if (!sig_q[10] && (exp_q > 7'd1)) begin
          sig_next    = {sig_q[10:0], guard_q};
          guard_next  = 1'b0;
          exp_next    = exp_q - 7'd1;
        end else if (!sig_q[10]) begin
          subn_next   = 1'b1;
          state_next  = ROUND;
        end else begin
          state_next  = ROUND;
        end
      end
      ROUND: begin
        inx_next = guard_q | sticky_q;
        if (rnd_ovf) begin
          result_next = {sign_q, 5'h1F, 10'h000};
          ovf_next    = 1'b1;
          unf_next    = 1'b0;
          inx_next    = 1'b1;
        end else begin
          result_next = {sign_q, rnd_field, rnd_frac};
          ovf_next    = 1'b0;
          unf_next    = (rnd_field == 5'd0) & (guard_q | sticky_q);
        end
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 7'd0;
      sig_q    <= 12'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      subn_q   <= 1'b0;
      result_q <= 16'h0000;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state    <= state_next;
      sign_q   <= sign_next;
      exp_q    <= exp_next;
      sig_q    <= sig_next;
      guard_q  <= guard_next;
      sticky_q <= sticky_next;
      subn_q   <= subn_next;
      result_q <= result_next;
      ovf_q    <= ovf_next;
      unf_q    <= unf_next;
      inx_q    <= inx_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp16_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_normalize_round
// Description : Directed vector table, handshake/reset sequences and random
//               operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_normalize_round;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp16_normalize_round_if bus();

  fp16_normalize_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sign;
    logic [4:0]  exp;
    logic [11:0] sig;
    logic        g;
    logic        s;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Value-level reference: the significand plus guard is one integer m
  // (LSB = guard weight) with sticky as a flag below it.
  function automatic void ref_model(
    input  logic        sg,
    input  logic [4:0]  ex,
    input  logic [11:0] sig,
    input  logic        g,
    input  logic        s,
    output logic [15:0] res,
    output logic        ovf,
    output logic        unf,
    output logic        inx,
    output int          lat
  );
    int e, m, st, q, gg, k;
    logic [4:0] field;
    logic [9:0] frac;
    ovf = 1'b0;
    unf = 1'b0;
    inx = 1'b0;
    if (sig == 0 && g == 0 && s == 0) begin
      res = {sg, 15'd0};
      lat = 2;
      return;
    end
    e  = (ex == 0) ? 1 : int'(ex);
    st = int'(s);
    m  = int'(sig) * 2 + int'(g);
    k  = 0;
    if (m >= 4096) begin
      st = st | (m % 2);
      m  = m / 2;
      e  = e + 1;
    end else begin
      while (m < 2048 && e > 1) begin
        m = m * 2;
        e = e - 1;
        k = k + 1;
      end
    end
    q   = m / 2;
    gg  = m % 2;
    inx = (gg != 0) || (st != 0);
    if (gg != 0 && (st != 0 || (q % 2) != 0)) q = q + 1;
    if (q >= 2048) begin
      q = q / 2;
      e = e + 1;
    end
    if (e >= 31) begin
      res = {sg, 5'h1F, 10'h000};
      ovf = 1'b1;
      inx = 1'b1;
    end else begin
      field = (q >= 1024) ? 5'(e) : 5'd0;
      frac  = 10'(q % 1024);
      res   = {sg, field, frac};
      unf   = (field == 5'd0) && inx;
    end
    lat = 3 + k;
  endfunction

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(
    input logic        sg,
    input logic [4:0]  ex,
    input logic [11:0] sig,
    input logic        g,
    input logic        s,
    input logic [15:0] e_res,
    input logic        e_ovf,
    input logic        e_unf,
    input logic        e_inx,
    input int          e_lat,
    input int          hold,
    input string       tag
  );
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_sign   = sg;
    bus.in_exp    = ex;
    bus.in_sig    = sig;
    bus.in_guard  = g;
    bus.in_sticky = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_sig    = 12'($urandom);
    bus.in_exp    = 5'($urandom);
    bus.in_guard  = 1'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (!seen) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
      pulse_reset();
      return;
    end
    check({tag, ".latency"},   32'(lat),               32'(e_lat));
    check({tag, ".result"},    32'(bus.out_result),    32'(e_res));
    check({tag, ".overflow"},  32'(bus.out_overflow),  32'(e_ovf));
    check({tag, ".underflow"}, 32'(bus.out_underflow), 32'(e_unf));
    check({tag, ".inexact"},   32'(bus.out_inexact),   32'(e_inx));
    check({tag, ".in_ready_busy"}, 32'(bus.in_ready),  32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".hold_valid"},  32'(bus.out_valid),  32'd1);
      check({tag, ".hold_result"}, 32'(bus.out_result), 32'(e_res));
      check({tag, ".hold_ready"},  32'(bus.in_ready),   32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic        sg, g, s, ovf, unf, inx;
    logic [4:0]  ex;
    logic [11:0] sig;
    logic [15:0] res;
    int          lat;

    vecs[0]  = '{1'b0, 5'd15, 12'h400, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 5'd15, 12'hC00, 1'b0, 1'b0, 16'h4200, 1'b0, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 5'd15, 12'h100, 1'b0, 1'b0, 16'h3400, 1'b0, 1'b0, 1'b0, 5};
    vecs[3]  = '{1'b0, 5'd15, 12'h401, 1'b1, 1'b0, 16'h3C02, 1'b0, 1'b0, 1'b1, 3};
    vecs[4]  = '{1'b0, 5'd15, 12'h400, 1'b1, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b0, 5'd15, 12'h400, 1'b1, 1'b1, 16'h3C01, 1'b0, 1'b0, 1'b1, 3};
    vecs[6]  = '{1'b1, 5'd30, 12'hFFF, 1'b0, 1'b0, 16'hFC00, 1'b1, 1'b0, 1'b1, 3};
    vecs[7]  = '{1'b0, 5'd1,  12'h200, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 5'd1,  12'h001, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 3};
    vecs[9]  = '{1'b1, 5'd7,  12'h000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b0, 5'd0,  12'h3FF, 1'b1, 1'b1, 16'h0400, 1'b0, 1'b0, 1'b1, 3};
    vecs[11] = '{1'b0, 5'd20, 12'h000, 1'b1, 1'b0, 16'h2400, 1'b0, 1'b0, 1'b0, 14};
    vecs[12] = '{1'b0, 5'd3,  12'h000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 5};
    vecs[13] = '{1'b0, 5'd15, 12'h7FF, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1, 3};
    vecs[14] = '{1'b0, 5'd31, 12'h400, 1'b0, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b1, 3};

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 5'd0;
    bus.in_sig    = 12'd0;
    bus.in_guard  = 1'b0;
    bus.in_sticky = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.in_ready",  32'(bus.in_ready),      32'd1);
    check("reset.out_valid", 32'(bus.out_valid),     32'd0);
    check("reset.result",    32'(bus.out_result),    32'd0);
    check("reset.flags",     32'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 32'd0);
    rst_n = 1'b1;

    // Directed table; the first entry also holds the result for 5 cycles.
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].sign, vecs[i].exp, vecs[i].sig, vecs[i].g, vecs[i].s,
             vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].inx, vecs[i].lat,
             (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // Reset while iterating in NORM.
    @(negedge clk);
    bus.in_sign = 1'b0; bus.in_exp = 5'd20; bus.in_sig = 12'h000;
    bus.in_guard = 1'b1; bus.in_sticky = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_norm.out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_norm.in_ready",  32'(bus.in_ready),   32'd1);
    check("rst_norm.result",    32'(bus.out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (bus.out_valid) check("rst_norm.ghost_result", 32'(bus.out_valid), 32'd0);
    end
    run_op(1'b0, 5'd15, 12'hC00, 1'b0, 1'b0, 16'h4200, 1'b0, 1'b0, 1'b0, 3, 0, "after_rst_norm");

    // Reset while a result is waiting in DONE.
    @(negedge clk);
    bus.in_sign = 1'b1; bus.in_exp = 5'd15; bus.in_sig = 12'h400;
    bus.in_guard = 1'b1; bus.in_sticky = 1'b1; bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_done.pre_valid",  32'(bus.out_valid),  32'd1);
    check("rst_done.pre_result", 32'(bus.out_result), 32'hBC01);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done.out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_done.result",    32'(bus.out_result), 32'd0);
    check("rst_done.inexact",   32'(bus.out_inexact), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 5'd1, 12'h001, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 3, 0, "after_rst_done");

    // Random operands against the reference model.
    for (int i = 0; i < 250; i++) begin
      sg  = 1'($urandom);
      ex  = 5'($urandom);
      sig = 12'($urandom_range(0, 4095) >> $urandom_range(0, 12));
      g   = 1'($urandom);
      s   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        sig = 12'd0;
        g   = 1'b0;
        s   = 1'b0;
      end
      ref_model(sg, ex, sig, g, s, res, ovf, unf, inx, lat);
      run_op(sg, ex, sig, g, s, res, ovf, unf, inx, lat,
             int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp16_normalize_round.md
# fp16_normalize_round

Post-add normalize-and-round stage for the half-precision (1/5/10) adder datapath. It sits directly downstream of the mantissa add/align stage and consumes that stage's significand sum, carry and round information. It normalizes the significand iteratively, one bit per cycle, then applies round-to-nearest-even and packs the IEEE 754 binary16 result. Valid/ready handshakes are used on both sides.

## Interface
- No parameters; widths are fixed to binary16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept input (high only in IDLE)
- in_sign  in  1  result sign
- in_exp  in  5  biased exponent of the aligned larger operand; 0 is treated as 1
- in_sig  in  12  significand sum: [11] carry, [10] hidden bit, [9:0] fraction
- in_guard  in  1  first bit shifted out during alignment
- in_sticky  in  1  OR of all remaining shifted-out bits
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts result
- out_result  out  16  packed binary16 {sign, exp[4:0], frac[9:0]}
- out_overflow  out  1  result rounded to infinity
- out_underflow  out  1  result is subnormal or zero and inexact
- out_inexact  out  1  guard or sticky nonzero after normalization

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- **IDLE:** in_ready=1. On in_valid&&in_ready, capture sign, exp (0 becomes 1), sig, guard and sticky, then go to NORM.
- **NORM:** evaluate in this priority order.
  - sig==0, guard==0, sticky==0: result is {sign, 15'b0} with all flags 0; go to DONE.
  - sig[11]=1: sig>>=1; new guard = old sig[0]; sticky |= old guard; exp+=1; go to ROUND.
  - sig[10]=0 and exp>1: sig<<=1 with guard shifted into bit 0; guard=0; sticky unchanged; exp-=1; stay in NORM.
  - sig[10]=0 and exp==1: subnormal; encoded exponent field becomes 0; go to ROUND.
  - Otherwise go to ROUND.
- **ROUND (round-to-nearest-even):**
  - inc = guard & (sticky | sig[0]).
  - sig[10:0] += inc. A carry out of bit 10 forces sig>>1 and exp+=1.
  - A subnormal that rounds up into bit 10 gets an exponent field of 1.
  - If exp >= 31: out_result = {sign, 5'h1F, 10'h0}, out_overflow=1, out_inexact=1.
  - Otherwise out_result = {sign, exp, sig[9:0]}.
  - out_inexact = guard|sticky, evaluated before the increment.
  - out_underflow = (exponent field==0) & out_inexact.
  - Go to DONE.
- **DONE:** out_valid=1. When out_ready=1, go to IDLE.
- Maximum NORM iterations: 12 (11 left shifts plus the exit cycle), which occurs when only guard is set.
- Outputs, including flags, are registered and stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=16'h0000, out_overflow=0, out_underflow=0, out_inexact=0. All internal registers are cleared.
- Reset takes effect immediately and asynchronously, including mid-NORM and mid-DONE. Any in-flight operation is discarded and no output is produced for it.
- Latency counts from the accepting clock edge to the first cycle with out_valid=1:
  - 3 cycles for an input that is already normalized or has carry set.
  - 3+k cycles for k left shifts.
  - 2 cycles for an exact zero.
- in_ready is a combinational decode of state==IDLE. A new input is never accepted in the same cycle as the result handshake.
- Throughput is one operation per (latency + 1) cycles at minimum.

## Test plan
- Normalized input: sign=0, exp=15, sig=0x400, guard=0, sticky=0. Required: out_result=0x3C00, all flags 0, out_valid 3 cycles after accept.
- Carry path: exp=15, sig=0xC00. Required: out_result=0x4200 (3.0). Left shifts: exp=15, sig=0x100. Required: out_result=0x3400, out_valid 5 cycles after accept.
- Round-to-nearest-even ties with exp=15:
  - sig=0x401, guard=1, sticky=0: out_result=0x3C02, inexact=1.
  - sig=0x400, guard=1, sticky=0: out_result=0x3C00, inexact=1.
  - sig=0x400, guard=1, sticky=1: out_result=0x3C01.
- Overflow: sign=1, exp=30, sig=0xFFF. Required: out_result=0xFC00, overflow=1, inexact=1.
- Subnormal and zero:
  - exp=1, sig=0x200: out_result=0x0200, underflow=0.
  - exp=1, sig=0x001, guard=1: out_result=0x0002, underflow=1.
  - sign=1, sig=0: out_result=0x8000, 2-cycle latency.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: out_result stays stable and in_ready=0 throughout.
  - Drop rst_n during NORM: out_valid=0 and in_ready=1 immediately, and the next accepted input produces a correct result.
